// File: rtl/pipe_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   PCSRC_*      : next-PC select encodings driven by the ID stage
//   NOP_WORD     : instruction word injected as a pipeline bubble
//   RESET_PC_DEF : default fetch address after reset
//   fetch_state_t: fetch FSM states (issuing a request / holding a word)
package pipe_pkg;

    localparam logic [1:0] PCSRC_PC4 = 2'b00;
    localparam logic [1:0] PCSRC_BPC = 2'b01;
    localparam logic [1:0] PCSRC_RPC = 2'b10;
    localparam logic [1:0] PCSRC_JPC = 2'b11;

    localparam logic [31:0] NOP_WORD     = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    typedef enum logic {
        S_REQ  = 1'b0,
        S_HOLD = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/pc_sel.sv
// Next-PC target selection.
//   rpend/rtgt : a redirect captured earlier; when pending it overrides everything
//   pcsource   : ID-stage select (pc+4, branch, jr register, jump)
//   pc4        : sequential next address
//   bpc/rpc/jpc: redirect targets
//   tgt        : address to load into the PC on the next accept
module pc_sel
    import pipe_pkg::*;
(
    input  logic        rpend,
    input  logic [31:0] rtgt,
    input  logic [1:0]  pcsource,
    input  logic [31:0] pc4,
    input  logic [31:0] bpc,
    input  logic [31:0] rpc,
    input  logic [31:0] jpc,
    output logic [31:0] tgt
);

    always_comb begin
        tgt = pc4;
        if (rpend) begin
            tgt = rtgt;
        end else begin
            case (pcsource)
                PCSRC_BPC: tgt = bpc;
                PCSRC_RPC: tgt = rpc;
                PCSRC_JPC: tgt = jpc;
                default:   tgt = pc4;
            endcase
        end
    end

endmodule

// File: rtl/pipeif.sv
// Instruction-fetch stage feeding the IF/ID pipeline register.
//   clk, clrn      : clock, asynchronous active-low reset
//   stall          : ID load-use stall, IF/ID must hold
//   pcsource       : next-PC select from ID; bpc/rpc/jpc are its targets
//   imem_addr/req  : fetch address and request to instruction memory
//   imem_rdata/rdy : returned word, valid when imem_ready is high
//   pc4, ins       : PC+4 and instruction presented to IF/ID
//   wpcir          : IF/ID load enable
//   dbg_st         : current fetch FSM state
//   dbg_rpend      : a redirect is waiting for its delay slot to be fetched
//
// Handshake: a fetch word is "valid" when memory answers a request this
// cycle, or when a previously answered word is held. It is consumed
// ("accepted") in any cycle where it is valid and stall is low; only then
// does the PC advance. A stalled answer is parked in a holding buffer so
// memory is not asked again.
module pipeif
    import pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] NOP      = NOP_WORD
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        stall,
    input  logic [1:0]  pcsource,
    input  logic [31:0] bpc,
    input  logic [31:0] rpc,
    input  logic [31:0] jpc,
    output logic [31:0] imem_addr,
    output logic        imem_req,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] pc4,
    output logic [31:0] ins,
    output logic        wpcir,
    output logic        dbg_st,
    output logic        dbg_rpend
);

    fetch_state_t st, st_next;
    logic [31:0]  pc;
    logic [31:0]  hold_buf;
    logic         rpend;
    logic [31:0]  rtgt;
    logic [31:0]  tgt;
    logic         valid;
    logic         accept;
    logic         capture;

    assign pc4       = pc + 32'd4;
    assign imem_addr = pc;
    assign imem_req  = (st == S_REQ);
    assign wpcir     = ~stall;
    assign dbg_st    = st;
    assign dbg_rpend = rpend;

    assign valid  = ((st == S_REQ) && imem_ready) || (st == S_HOLD);
    assign accept = valid && !stall;
    assign ins    = valid ? ((st == S_HOLD) ? hold_buf : imem_rdata) : NOP;

    // A branch leaving ID while its delay slot has not arrived yet: remember
    // the target so the delay slot still goes to the old PC's word. A pending
    // redirect wins over any later select (none should arrive behind bubbles).
    assign capture = !stall && (pcsource != PCSRC_PC4) && !valid && !rpend;

    pc_sel u_pc_sel (
        .rpend    (rpend),
        .rtgt     (rtgt),
        .pcsource (pcsource),
        .pc4      (pc4),
        .bpc      (bpc),
        .rpc      (rpc),
        .jpc      (jpc),
        .tgt      (tgt)
    );

    // FSM state register
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            st <= S_REQ;
        end else begin
            st <= st_next;
        end
    end

    // FSM next state
    always_comb begin
        st_next = st;
        case (st)
            S_REQ:  if (imem_ready && stall) st_next = S_HOLD;
            S_HOLD: if (!stall)              st_next = S_REQ;
            default:                         st_next = S_REQ;
        endcase
    end

    // PC register: loads only when the current word is consumed
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            pc <= RESET_PC;
        end else if (accept) begin
            pc <= tgt;
        end
    end

    // Holding buffer for a word answered during a stall
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            hold_buf <= 32'h0000_0000;
        end else if ((st == S_REQ) && imem_ready && stall) begin
            hold_buf <= imem_rdata;
        end
    end

    // Pending redirect
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            rpend <= 1'b0;
            rtgt  <= 32'h0000_0000;
        end else if (accept) begin
            rpend <= 1'b0;
        end else if (capture) begin
            rpend <= 1'b1;
            rtgt  <= tgt;
        end
    end

endmodule

// File: tb/tb_pipeif.sv
// Self-checking bench for pipeif: directed cycle-by-cycle stimulus with the
// expected outputs of each cycle pushed to a queue and compared on the
// falling edge.
module tb_pipeif;

    localparam int W = 99;  // {addr32, req1, ins32, pc4_32, wpcir1, rpend1}
    localparam logic [31:0] NOPW = 32'h0000_0000;

    logic        clk;
    logic        clrn;
    logic        stall;
    logic [1:0]  pcsource;
    logic [31:0] bpc;
    logic [31:0] rpc;
    logic [31:0] jpc;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic [31:0] pc4;
    logic [31:0] ins;
    logic        wpcir;
    logic        dbg_st;
    logic        dbg_rpend;

    logic [W-1:0] exp_q[$];
    int checks;
    int failures;

    pipeif dut (
        .clk        (clk),
        .clrn       (clrn),
        .stall      (stall),
        .pcsource   (pcsource),
        .bpc        (bpc),
        .rpc        (rpc),
        .jpc        (jpc),
        .imem_addr  (imem_addr),
        .imem_req   (imem_req),
        .imem_rdata (imem_rdata),
        .imem_ready (imem_ready),
        .pc4        (pc4),
        .ins        (ins),
        .wpcir      (wpcir),
        .dbg_st     (dbg_st),
        .dbg_rpend  (dbg_rpend)
    );

    // clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Pop one expected record and compare every output against it.
    task automatic compare_outputs(input string tag);
        logic [W-1:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            e = exp_q.pop_front();
            check({tag, ".addr"},  imem_addr,          e[98:67]);
            check({tag, ".req"},   {31'd0, imem_req},  {31'd0, e[66]});
            check({tag, ".ins"},   ins,                e[65:34]);
            check({tag, ".pc4"},   pc4,                e[33:2]);
            check({tag, ".wpcir"}, {31'd0, wpcir},     {31'd0, e[1]});
            check({tag, ".rpend"}, {31'd0, dbg_rpend}, {31'd0, e[0]});
        end
    endtask

    // One clock cycle: drive inputs just after the rising edge, record the
    // expected outputs, compare on the falling edge.
    task automatic cyc(input string tag, input logic s, input logic [1:0] ps,
                       input logic rdy, input logic [31:0] rd,
                       input logic [31:0] e_addr, input logic e_req,
                       input logic [31:0] e_ins, input logic [31:0] e_pc4,
                       input logic e_rpend);
        stall      = s;
        pcsource   = ps;
        imem_ready = rdy;
        imem_rdata = rd;
        exp_q.push_back({e_addr, e_req, e_ins, e_pc4, ~s, e_rpend});
        @(negedge clk);
        compare_outputs(tag);
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        clrn       = 1'b0;
        stall      = 1'b0;
        pcsource   = 2'b00;
        bpc        = 32'h0;
        rpc        = 32'h0;
        jpc        = 32'h0;
        imem_ready = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;

        // reset state
        exp_q.push_back({32'h0, 1'b1, NOPW, 32'h4, 1'b1, 1'b0});
        @(negedge clk);
        compare_outputs("reset");
        @(posedge clk);
        #1;
        clrn = 1'b1;

        // zero-wait sequential fetch
        cyc("seq0", 0, 2'b00, 1, 32'hA0, 32'h0, 1, 32'hA0, 32'h4, 0);
        cyc("seq1", 0, 2'b00, 1, 32'hA1, 32'h4, 1, 32'hA1, 32'h8, 0);
        cyc("seq2", 0, 2'b00, 1, 32'hA2, 32'h8, 1, 32'hA2, 32'hC, 0);

        // memory wait states: bubbles, PC holds
        cyc("wait0", 0, 2'b00, 0, 32'h1111_1111, 32'hC, 1, NOPW, 32'h10, 0);
        cyc("wait1", 0, 2'b00, 0, 32'h2222_2222, 32'hC, 1, NOPW, 32'h10, 0);
        cyc("wait2", 0, 2'b00, 1, 32'hA3, 32'hC, 1, 32'hA3, 32'h10, 0);

        // load-use stall: word parked, request dropped, memory input ignored
        cyc("stl0", 1, 2'b00, 1, 32'hB0, 32'h10, 1, 32'hB0, 32'h14, 0);
        cyc("stl1", 1, 2'b00, 1, 32'h3333_3333, 32'h10, 0, 32'hB0, 32'h14, 0);
        cyc("stl2", 1, 2'b00, 0, 32'h4444_4444, 32'h10, 0, 32'hB0, 32'h14, 0);
        cyc("stl3", 0, 2'b00, 1, 32'h5555_5555, 32'h10, 0, 32'hB0, 32'h14, 0);
        cyc("stl4", 0, 2'b00, 1, 32'hC0, 32'h14, 1, 32'hC0, 32'h18, 0);
        cyc("seq3", 0, 2'b00, 1, 32'hC1, 32'h18, 1, 32'hC1, 32'h1C, 0);
        cyc("seq4", 0, 2'b00, 1, 32'hC2, 32'h1C, 1, 32'hC2, 32'h20, 0);

        // branch with delay slot ready: slot delivered, then target
        bpc = 32'h100;
        cyc("br0", 0, 2'b01, 1, 32'hD0, 32'h20, 1, 32'hD0, 32'h24, 0);
        cyc("br1", 0, 2'b00, 1, 32'hD1, 32'h100, 1, 32'hD1, 32'h104, 0);
        rpc = 32'h40;
        cyc("jr0", 0, 2'b10, 1, 32'hD2, 32'h104, 1, 32'hD2, 32'h108, 0);

        // jump while delay slot is not yet fetched: redirect remembered
        jpc = 32'h200;
        cyc("jp0", 0, 2'b11, 0, 32'h6666_6666, 32'h40, 1, NOPW, 32'h44, 0);
        bpc = 32'h500;  // a stray select while pending must be ignored
        cyc("jp1", 0, 2'b01, 0, 32'h7777_7777, 32'h40, 1, NOPW, 32'h44, 1);
        cyc("jp2", 0, 2'b00, 1, 32'hE0, 32'h40, 1, 32'hE0, 32'h44, 1);
        cyc("jp3", 0, 2'b00, 1, 32'hE1, 32'h200, 1, 32'hE1, 32'h204, 0);

        // reset mid-wait with a pending redirect
        jpc = 32'h300;
        cyc("rs0", 0, 2'b11, 1, 32'hE2, 32'h204, 1, 32'hE2, 32'h208, 0);
        rpc = 32'h700;
        cyc("rs1", 0, 2'b10, 0, 32'h8888_8888, 32'h300, 1, NOPW, 32'h304, 0);
        cyc("rs2", 0, 2'b00, 0, 32'h9999_9999, 32'h300, 1, NOPW, 32'h304, 1);
        imem_ready = 1'b0;
        #2;
        clrn = 1'b0;
        #1;
        check("rs_async.addr",  imem_addr, 32'h0);
        check("rs_async.rpend", {31'd0, dbg_rpend}, 32'h0);
        #1;
        clrn = 1'b1;
        @(posedge clk);
        #1;
        cyc("rs3", 0, 2'b00, 0, 32'hAAAA_AAAA, 32'h0, 1, NOPW, 32'h4, 0);
        cyc("rs4", 0, 2'b00, 1, 32'hF0, 32'h0, 1, 32'hF0, 32'h4, 0);

        // pc4 wrap at the top of the address space
        jpc = 32'hFFFF_FFFC;
        cyc("wr0", 0, 2'b11, 1, 32'hF1, 32'h4, 1, 32'hF1, 32'h8, 0);
        cyc("wr1", 0, 2'b00, 1, 32'hF2, 32'hFFFF_FFFC, 1, 32'hF2, 32'h0, 0);
        cyc("wr2", 0, 2'b00, 1, 32'hF3, 32'h0, 1, 32'hF3, 32'h4, 0);

        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain: %0d expected records left", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
